phase_timer: RTL and testbench
==============================

# phase_timer

Loadable down-counting phase timer that consumes the 1 Hz tick strobe produced by the clock divider and tells the traffic-light sequencer when a light phase has elapsed. The sequencer loads a duration in ticks, and the timer counts down one per tick. It supports pause and reports completion with a single-cycle `done` pulse. The block sits between the divider output and the light-sequencing FSM, all on the system clock.

## Interface
- `CNT_W`, default 8: width of the duration/remaining count, in ticks.
- `clk`  input  1  system clock; all state updates on its rising edge.
- `reset`  input  1  asynchronous, active-low reset. Low clears all state immediately.
- `tick`  input  1  divider strobe, synchronous to `clk`. Only its rising edge counts, so a level held high for several cycles equals one tick.
- `load`  input  1  single-cycle request to start or restart a phase.
- `load_val`  input  `CNT_W`  phase duration in ticks, sampled when `load`=1.
- `pause`  input  1  level; while high, ticks are not counted.
- `remaining`  output  `CNT_W`  ticks left in the current phase.
- `busy`  output  1  high while the timer is in RUN or PAUSE.
- `done`  output  1  registered one-cycle pulse when a phase completes.

## Operation
- Reset values: state IDLE, `remaining`=0, `busy`=0, `done`=0, tick history register=0.
- Tick qualification: `tick_rise` = `tick` & ~`tick_q`, where `tick_q` is `tick` registered one cycle.
- States:
  - **IDLE**: `busy`=0. Ticks and `pause` are ignored, and `remaining` holds its value.
  - **RUN**: `busy`=1. Each `tick_rise` with `pause`=0 decrements `remaining` by 1.
  - **PAUSE**: `busy`=1. `remaining` is frozen and `tick_rise` is discarded, not deferred.
- Transitions:
  - Any state, `load`=1 and `load_val`≠0: `remaining`←`load_val`, next state RUN, or PAUSE if `pause`=1.
  - Any state, `load`=1 and `load_val`=0: `remaining`←0, `done` pulses next cycle, next state IDLE.
  - RUN, `pause`=1: go to PAUSE. PAUSE, `pause`=0: go to RUN.
  - RUN, `tick_rise` and `remaining`=1: `remaining`←0, `done`←1 for one cycle, next state IDLE.
- Priority within one cycle: `load` > `tick_rise`. A tick coinciding with `load` is dropped.
- `pause` is evaluated before `tick_rise`. A tick arriving in the same cycle that `pause` rises is not counted.
- Restart: `load` in RUN or PAUSE reloads the count. No `done` is issued for the aborted phase.
- Arithmetic:
  - Unsigned, `CNT_W` bits; the counter never underflows.
  - `remaining`=0 occurs only in IDLE.
  - The maximum phase length is 2^`CNT_W`−1 ticks.
- `done` is never high on two consecutive cycles except for back-to-back zero loads.

## Timing
- `load` sampled at edge k: `remaining`=`load_val` and `busy`=1 visible after edge k.
- Decrement: `tick` rising sampled at edge m (`tick`=1, `tick_q`=0) gives the new `remaining` after edge m.
- Completion: after the Nth qualified tick (edge m), `remaining`=0, `busy`=0 and `done`=1 after edge m; `done`=0 after edge m+1.
- Zero load at edge k: `done`=1 after edge k, for one cycle.
- Pause takes effect at the edge where `pause`=1 is sampled, with no extra latency.
- Reset asserted mid-phase: all outputs clear asynchronously. The aborted phase produces no `done`, and the timer restarts only via `load` after reset is released.

## Structure
- Shared package `traffic_pkg`:
  - state enum `timer_state_t` (IDLE, RUN, PAUSE);
  - default `CNT_W` constant, shared with the sequencer;
  - the phase-duration constants the sequencer loads.
- Sub-module `tick_edge`: registers `tick` and outputs `tick_rise`; async active-low reset clears its history to 0.
- Top level: state register, counter register and `done` register.

## Test plan
- Reset, then `load_val`=3 and five 1-cycle ticks: `remaining` steps 3→2→1→0. `done` pulses once after the 3rd tick, `busy` falls with it, and ticks 4–5 are ignored.
- `load_val`=2, then `tick` held high for 4 cycles followed by one more pulse: the held level counts once, `remaining` goes 2→1→0, and `done` pulses after the second rising edge.
- `load_val`=4, two ticks, then `pause`=1 over three ticks, release, two more ticks: `remaining` goes 4,3,2, holds at 2, then 1,0 with `done` at the end.
- `load_val`=5, after one tick `load_val`=7 with `tick_rise` in the same cycle: `remaining`=7 (tick dropped), and no `done` is issued for the first phase.
- `load_val`=0: `done`=1 for exactly one cycle, `busy` stays 0, `remaining`=0.
- `load_val`=6, two ticks, then `reset` low for half a cycle: `remaining`=0, `busy`=0, `done`=0 immediately. After release, ticks have no effect until the next `load`.

Source files
------------

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared types and constants for the traffic-light timing path
package traffic_pkg;

    // Default counter width, shared by the phase timer and the sequencer.
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } timer_state_t;

    // Phase durations in 1 Hz ticks, loaded by the sequencer.
    localparam logic [CNT_W_DEF-1:0] GREEN_TICKS  = 8'd30;
    localparam logic [CNT_W_DEF-1:0] YELLOW_TICKS = 8'd4;
    localparam logic [CNT_W_DEF-1:0] RED_TICKS    = 8'd25;
    localparam logic [CNT_W_DEF-1:0] ALL_RED_TICKS = 8'd2;

endpackage

// File: rtl/tick_edge.sv
// rtl/tick_edge.sv - rising-edge qualifier for the divider tick strobe
//
// Ports:
//   clk       system clock
//   reset     asynchronous active-low reset, clears the tick history
//   tick      divider strobe (level may be held for several cycles)
//   tick_rise one-cycle pulse on each 0->1 transition of tick
module tick_edge (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    output logic tick_rise
);

    logic tick_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick;
        end
    end

    assign tick_rise = tick & ~tick_q;

endmodule

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable down-counting phase timer with pause and done pulse
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   tick       1 Hz divider strobe; only its rising edge is counted
//   load       single-cycle start/restart request
//   load_val   phase duration in ticks, sampled with load
//   pause      level; while high, ticks are not counted
//   remaining  ticks left in the current phase
//   busy       high while running or paused
//   done       registered one-cycle pulse at phase completion
module phase_timer
    import traffic_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             pause,
    output logic [CNT_W-1:0] remaining,
    output logic             busy,
    output logic             done
);

    timer_state_t     state_q, state_nxt;
    logic [CNT_W-1:0] remaining_q, remaining_nxt;
    logic             done_q, done_nxt;
    logic             tick_rise;

    tick_edge u_tick_edge (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .tick_rise (tick_rise)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            remaining_q <= remaining_nxt;
            done_q      <= done_nxt;
        end
    end

    // load wins over everything; within RUN, pause is looked at before the
    // tick so a tick landing on the cycle pause rises is dropped.
    always_comb begin
        state_nxt     = state_q;
        remaining_nxt = remaining_q;
        done_nxt      = 1'b0;

        if (load) begin
            if (load_val != '0) begin
                remaining_nxt = load_val;
                state_nxt     = pause ? PAUSE : RUN;
            end else begin
                remaining_nxt = '0;
                done_nxt      = 1'b1;
                state_nxt     = IDLE;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (pause) begin
                        state_nxt = PAUSE;
                    end else if (tick_rise) begin
                        if (remaining_q == CNT_W'(1)) begin
                            remaining_nxt = '0;
                            done_nxt      = 1'b1;
                            state_nxt     = IDLE;
                        end else begin
                            remaining_nxt = remaining_q - CNT_W'(1);
                        end
                    end
                end
                PAUSE: begin
                    // Ticks seen while paused are discarded, not deferred.
                    if (!pause) begin
                        state_nxt = RUN;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    assign remaining = remaining_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_phase_timer.sv
// tb/tb_phase_timer.sv - self-checking scoreboard testbench for phase_timer
module tb_phase_timer;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         tick;
    logic         load;
    logic [W-1:0] load_val;
    logic         pause;
    logic [W-1:0] remaining;
    logic         busy;
    logic         done;

    int checks;
    int errors;

    typedef struct {
        logic [W-1:0] rem;
        logic         busy;
        logic         done;
        string        name;
    } exp_t;

    exp_t sb_q[$];

    phase_timer #(.CNT_W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .load      (load),
        .load_val  (load_val),
        .pause     (pause),
        .remaining (remaining),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus, push the expected post-edge outputs, then
    // pop and compare once the DUT has clocked them out.
    task automatic step(input logic t, input logic ld, input logic [W-1:0] lv,
                        input logic p, input logic [W-1:0] e_rem,
                        input logic e_busy, input logic e_done, input string name);
        exp_t e;
        exp_t got;
        tick     = t;
        load     = ld;
        load_val = lv;
        pause    = p;
        e.rem  = e_rem;
        e.busy = e_busy;
        e.done = e_done;
        e.name = name;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty", name);
        end else begin
            got = sb_q.pop_front();
            checks++;
            if (remaining !== got.rem) begin
                errors++;
                $display("FAIL %s remaining got %0d expected %0d", got.name, remaining, got.rem);
            end
            checks++;
            if (busy !== got.busy) begin
                errors++;
                $display("FAIL %s busy got %b expected %b", got.name, busy, got.busy);
            end
            checks++;
            if (done !== got.done) begin
                errors++;
                $display("FAIL %s done got %b expected %b", got.name, done, got.done);
            end
        end
        load = 1'b0;
    endtask

    task automatic test_reset();
        tick = 1'b0; load = 1'b0; load_val = '0; pause = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (remaining !== 8'd0) begin errors++; $display("FAIL reset_remaining got %0d expected 0", remaining); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done); end
        reset = 1'b1;
        step(0, 0, 0, 0, 8'd0, 0, 0, "reset_idle");
    endtask

    task automatic test_basic_count();
        step(0, 1, 8'd3, 0, 8'd3, 1, 0, "basic_load");
        step(1, 0, 0, 0, 8'd2, 1, 0, "basic_t1");
        step(0, 0, 0, 0, 8'd2, 1, 0, "basic_t1_low");
        step(1, 0, 0, 0, 8'd1, 1, 0, "basic_t2");
        step(0, 0, 0, 0, 8'd1, 1, 0, "basic_t2_low");
        step(1, 0, 0, 0, 8'd0, 0, 1, "basic_t3_done");
        step(0, 0, 0, 0, 8'd0, 0, 0, "basic_done_clear");
        step(1, 0, 0, 0, 8'd0, 0, 0, "basic_t4_ignored");
        step(0, 0, 0, 0, 8'd0, 0, 0, "basic_t4_low");
        step(1, 0, 0, 0, 8'd0, 0, 0, "basic_t5_ignored");
        step(0, 0, 0, 0, 8'd0, 0, 0, "basic_t5_low");
    endtask

    task automatic test_held_tick();
        step(0, 1, 8'd2, 0, 8'd2, 1, 0, "held_load");
        step(1, 0, 0, 0, 8'd1, 1, 0, "held_c1");
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 8'd1, 1, 0, "held_level");
        step(0, 0, 0, 0, 8'd1, 1, 0, "held_low");
        step(1, 0, 0, 0, 8'd0, 0, 1, "held_second_done");
        step(0, 0, 0, 0, 8'd0, 0, 0, "held_done_clear");
    endtask

    task automatic test_pause();
        step(0, 1, 8'd4, 0, 8'd4, 1, 0, "pause_load");
        step(1, 0, 0, 0, 8'd3, 1, 0, "pause_t1");
        step(0, 0, 0, 0, 8'd3, 1, 0, "pause_t1_low");
        step(1, 0, 0, 0, 8'd2, 1, 0, "pause_t2");
        step(0, 0, 0, 0, 8'd2, 1, 0, "pause_t2_low");
        // Tick coinciding with the rising pause must be dropped.
        step(1, 0, 0, 1, 8'd2, 1, 0, "pause_rise_tick");
        step(0, 0, 0, 1, 8'd2, 1, 0, "pause_hold_low");
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 0, 1, 8'd2, 1, 0, "pause_tick_drop");
            step(0, 0, 0, 1, 8'd2, 1, 0, "pause_tick_low");
        end
        step(0, 0, 0, 0, 8'd2, 1, 0, "pause_release");
        step(1, 0, 0, 0, 8'd1, 1, 0, "pause_t3");
        step(0, 0, 0, 0, 8'd1, 1, 0, "pause_t3_low");
        step(1, 0, 0, 0, 8'd0, 0, 1, "pause_t4_done");
        step(0, 0, 0, 0, 8'd0, 0, 0, "pause_done_clear");
    endtask

    task automatic test_restart();
        step(0, 1, 8'd5, 0, 8'd5, 1, 0, "restart_load5");
        step(1, 0, 0, 0, 8'd4, 1, 0, "restart_t1");
        step(0, 0, 0, 0, 8'd4, 1, 0, "restart_t1_low");
        step(1, 1, 8'd7, 0, 8'd7, 1, 0, "restart_load7_tick");
        step(0, 0, 0, 0, 8'd7, 1, 0, "restart_hold");
        step(1, 0, 0, 0, 8'd6, 1, 0, "restart_t2");
        step(0, 0, 0, 0, 8'd6, 1, 0, "restart_t2_low");
    endtask

    task automatic test_zero_load();
        // Zero load from a running phase ends it at once with a done pulse.
        step(0, 1, 8'd0, 0, 8'd0, 0, 1, "zero_load");
        step(0, 0, 0, 0, 8'd0, 0, 0, "zero_done_clear");
        step(0, 1, 8'd0, 0, 8'd0, 0, 1, "zero_b2b_a");
        step(0, 1, 8'd0, 0, 8'd0, 0, 1, "zero_b2b_b");
        step(1, 0, 0, 0, 8'd0, 0, 0, "zero_idle_tick");
        step(0, 0, 0, 0, 8'd0, 0, 0, "zero_idle_low");
    endtask

    task automatic test_max_load();
        step(0, 1, 8'd255, 1, 8'd255, 1, 0, "max_load_paused");
        step(1, 0, 0, 1, 8'd255, 1, 0, "max_paused_tick");
        step(0, 0, 0, 0, 8'd255, 1, 0, "max_release");
        step(1, 0, 0, 0, 8'd254, 1, 0, "max_t1");
        step(0, 1, 8'd1, 0, 8'd1, 1, 0, "max_reload1");
        step(1, 0, 0, 0, 8'd0, 0, 1, "max_one_done");
        step(0, 0, 0, 0, 8'd0, 0, 0, "max_done_clear");
    endtask

    task automatic test_async_reset();
        step(0, 1, 8'd6, 0, 8'd6, 1, 0, "areset_load");
        step(1, 0, 0, 0, 8'd5, 1, 0, "areset_t1");
        step(0, 0, 0, 0, 8'd5, 1, 0, "areset_t1_low");
        step(1, 0, 0, 0, 8'd4, 1, 0, "areset_t2");
        tick = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (remaining !== 8'd0) begin errors++; $display("FAIL areset_remaining got %0d expected 0", remaining); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy got %b expected 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL areset_done got %b expected 0", done); end
        #4;
        reset = 1'b1;
        step(1, 0, 0, 0, 8'd0, 0, 0, "areset_post_t1");
        step(0, 0, 0, 0, 8'd0, 0, 0, "areset_post_low");
        step(1, 0, 0, 0, 8'd0, 0, 0, "areset_post_t2");
        step(0, 1, 8'd1, 0, 8'd1, 1, 0, "areset_reload");
        step(1, 0, 0, 0, 8'd0, 0, 1, "areset_reload_done");
        step(0, 0, 0, 0, 8'd0, 0, 0, "areset_done_clear");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic_count();
        test_held_tick();
        test_pause();
        test_restart();
        test_zero_load();
        test_max_load();
        test_async_reset();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d entries expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
